// File: rtl/button_events_if.sv
// Button level input and per-button event outputs of button_events.
// SV keywords prevent naming the pulses "release"/"repeat", hence the _ev suffix.
interface button_events_if;
  logic [4:0] btn_in;
  logic [4:0] press;
  logic [4:0] release_ev;
  logic [4:0] long_press;
  logic [4:0] repeat_ev;
  logic [4:0] held;
  logic       any_event;

  modport master (
    output btn_in,
    input  press, release_ev, long_press, repeat_ev, held, any_event
  );

  modport slave (
    input  btn_in,
    output press, release_ev, long_press, repeat_ev, held, any_event
  );
endinterface

// File: rtl/button_events.sv
// Five independent press/long-press/auto-repeat/release detectors.
// Auto-repeat is built only when BTN_REPEAT_EN is defined.
//
// state  | meaning
// S_IDLE | button released
// S_WAIT | pressed, counting towards HOLD_TIME
// S_HELD | long press reached, counting repeat intervals
module button_events #(
  parameter int unsigned HOLD_TIME   = 50000000,
  parameter int unsigned REPEAT_TIME = 10000000,
  parameter int unsigned CNT_W       = 26
) (
  input logic           clock,
  input logic           reset,
  button_events_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TIME - 1);
`endif

  state_t           state_q [5];
  state_t           state_d [5];
  logic [CNT_W-1:0] cnt_q   [5];
  logic [CNT_W-1:0] cnt_d   [5];

  logic [4:0] press_d, release_d, long_d, repeat_d, held_d;
  logic [4:0] press_q, release_q, long_q, repeat_q, held_q;
  logic       any_q;

  always_comb begin
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    held_d    = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (bus.btn_in[i]) begin
            state_d[i] = S_WAIT;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.btn_in[i]) begin
            state_d[i]   = S_IDLE;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else if (cnt_q[i] == HOLD_LAST) begin
            state_d[i] = S_HELD;
            cnt_d[i]   = '0;
            long_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_HELD: begin
          if (!bus.btn_in[i]) begin
            state_d[i]   = S_IDLE;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
`ifdef BTN_REPEAT_EN
            if (cnt_q[i] == REP_LAST) begin
              cnt_d[i]    = '0;
              repeat_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
`else
            cnt_d[i] = '0;
`endif
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == S_HELD);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      held_q    <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      // any_event trails the registered pulses by one cycle
      any_q     <= |{press_q, long_q, repeat_q};
    end
  end

  assign bus.press      = press_q;
  assign bus.release_ev = release_q;
  assign bus.long_press = long_q;
  assign bus.repeat_ev  = repeat_q;
  assign bus.held       = held_q;
  assign bus.any_event  = any_q;

endmodule

// File: tb/tb_button_events.sv
// Directed self-checking bench for button_events with HOLD_TIME=4, REPEAT_TIME=3.
// Repeat expectations follow whether BTN_REPEAT_EN is defined for the build.
module tb_button_events;

`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  button_events_if bus ();

  button_events #(.HOLD_TIME(4), .REPEAT_TIME(3), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.btn_in = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.btn_in = '0;
    #2;
    n_checks++; if (bus.press !== 5'b0) begin n_fail++; $display("FAIL reset_press got=%b exp=%b", bus.press, 5'b0); end
    n_checks++; if (bus.release_ev !== 5'b0) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", bus.release_ev, 5'b0); end
    n_checks++; if (bus.long_press !== 5'b0) begin n_fail++; $display("FAIL reset_long got=%b exp=%b", bus.long_press, 5'b0); end
    n_checks++; if (bus.repeat_ev !== 5'b0) begin n_fail++; $display("FAIL reset_repeat got=%b exp=%b", bus.repeat_ev, 5'b0); end
    n_checks++; if (bus.held !== 5'b0) begin n_fail++; $display("FAIL reset_held got=%b exp=%b", bus.held, 5'b0); end
    n_checks++; if (bus.any_event !== 1'b0) begin n_fail++; $display("FAIL reset_any got=%b exp=%b", bus.any_event, 1'b0); end
    tick();
    tick();
    #2 reset = 1'b0;
    idle(2);
  endtask

  // 12-cycle hold on one button: press k, long k+4, repeats k+7/k+10, release k+12
  task automatic test_long_hold(input int b);
    logic [4:0] m, e_p, e_l, e_r, e_x, e_h;
    logic       e_any, prev_any;
    m = 5'b1 << b;
    prev_any = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      bus.btn_in = (j < 12) ? m : 5'b0;
      tick();
      e_p = (j == 0) ? m : 5'b0;
      e_l = (j == 4) ? m : 5'b0;
      e_r = (REP_EN && (j == 7 || j == 10)) ? m : 5'b0;
      e_x = (j == 12) ? m : 5'b0;
      e_h = (j >= 4 && j < 12) ? m : 5'b0;
      e_any = prev_any;
      n_checks++; if (bus.press !== e_p) begin n_fail++; $display("FAIL hold%0d_press j=%0d got=%b exp=%b", b, j, bus.press, e_p); end
      n_checks++; if (bus.long_press !== e_l) begin n_fail++; $display("FAIL hold%0d_long j=%0d got=%b exp=%b", b, j, bus.long_press, e_l); end
      n_checks++; if (bus.repeat_ev !== e_r) begin n_fail++; $display("FAIL hold%0d_repeat j=%0d got=%b exp=%b", b, j, bus.repeat_ev, e_r); end
      n_checks++; if (bus.release_ev !== e_x) begin n_fail++; $display("FAIL hold%0d_release j=%0d got=%b exp=%b", b, j, bus.release_ev, e_x); end
      n_checks++; if (bus.held !== e_h) begin n_fail++; $display("FAIL hold%0d_held j=%0d got=%b exp=%b", b, j, bus.held, e_h); end
      n_checks++; if (bus.any_event !== e_any) begin n_fail++; $display("FAIL hold%0d_any j=%0d got=%b exp=%b", b, j, bus.any_event, e_any); end
      prev_any = |{e_p, e_l, e_r};
    end
    idle(2);
  endtask

  task automatic test_short_press;
    for (int j = 0; j <= 2; j++) begin
      bus.btn_in = (j < 2) ? 5'b00100 : 5'b0;
      tick();
      n_checks++; if (bus.press !== ((j == 0) ? 5'b00100 : 5'b0)) begin n_fail++; $display("FAIL short_press j=%0d got=%b", j, bus.press); end
      n_checks++; if (bus.release_ev !== ((j == 2) ? 5'b00100 : 5'b0)) begin n_fail++; $display("FAIL short_release j=%0d got=%b", j, bus.release_ev); end
      n_checks++; if (bus.long_press !== 5'b0) begin n_fail++; $display("FAIL short_long j=%0d got=%b exp=00000", j, bus.long_press); end
      n_checks++; if (bus.held !== 5'b0) begin n_fail++; $display("FAIL short_held j=%0d got=%b exp=00000", j, bus.held); end
    end
    idle(2);
  endtask

  task automatic test_simultaneous;
    bus.btn_in = 5'b10010;
    tick();
    n_checks++; if (bus.press !== 5'b10010) begin n_fail++; $display("FAIL simul_press got=%b exp=10010", bus.press); end
    n_checks++; if (bus.any_event !== 1'b0) begin n_fail++; $display("FAIL simul_any0 got=%b exp=0", bus.any_event); end
    tick();
    n_checks++; if (bus.press !== 5'b0) begin n_fail++; $display("FAIL simul_press_clr got=%b exp=00000", bus.press); end
    n_checks++; if (bus.any_event !== 1'b1) begin n_fail++; $display("FAIL simul_any1 got=%b exp=1", bus.any_event); end
    bus.btn_in = 5'b0;
    tick();
    n_checks++; if (bus.release_ev !== 5'b10010) begin n_fail++; $display("FAIL simul_release got=%b exp=10010", bus.release_ev); end
    idle(2);
  endtask

  task automatic test_release_at_long;
    for (int j = 0; j <= 4; j++) begin
      bus.btn_in = (j < 4) ? 5'b00001 : 5'b0;
      tick();
    end
    n_checks++; if (bus.release_ev !== 5'b00001) begin n_fail++; $display("FAIL edge_release got=%b exp=00001", bus.release_ev); end
    n_checks++; if (bus.long_press !== 5'b0) begin n_fail++; $display("FAIL edge_long got=%b exp=00000", bus.long_press); end
    n_checks++; if (bus.held !== 5'b0) begin n_fail++; $display("FAIL edge_held got=%b exp=00000", bus.held); end
    tick();
    n_checks++; if (bus.long_press !== 5'b0) begin n_fail++; $display("FAIL edge_long_late got=%b exp=00000", bus.long_press); end
    idle(2);
  endtask

  task automatic test_reset_mid_hold;
    bus.btn_in = 5'b00010;
    for (int j = 0; j <= 5; j++) tick();
    n_checks++; if (bus.held !== 5'b00010) begin n_fail++; $display("FAIL rst_pre_held got=%b exp=00010", bus.held); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({bus.press, bus.release_ev, bus.long_press, bus.repeat_ev, bus.held, bus.any_event} !== 26'b0)
      begin n_fail++; $display("FAIL rst_async got=%b exp=0", {bus.press, bus.release_ev, bus.long_press, bus.repeat_ev, bus.held, bus.any_event}); end
    #1 reset = 1'b0;
    tick();
    n_checks++; if (bus.press !== 5'b00010) begin n_fail++; $display("FAIL rst_repress got=%b exp=00010", bus.press); end
    n_checks++; if (bus.release_ev !== 5'b0) begin n_fail++; $display("FAIL rst_no_release got=%b exp=00000", bus.release_ev); end
    n_checks++; if (bus.held !== 5'b0) begin n_fail++; $display("FAIL rst_held got=%b exp=00000", bus.held); end
    bus.btn_in = 5'b0;
    tick();
    n_checks++; if (bus.release_ev !== 5'b00010) begin n_fail++; $display("FAIL rst_release got=%b exp=00010", bus.release_ev); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    bus.btn_in = 5'b10000;
    tick();
    n_checks++; if (bus.press !== 5'b10000) begin n_fail++; $display("FAIL pulse_press got=%b exp=10000", bus.press); end
    bus.btn_in = 5'b0;
    tick();
    n_checks++; if (bus.release_ev !== 5'b10000) begin n_fail++; $display("FAIL pulse_release got=%b exp=10000", bus.release_ev); end
    n_checks++; if (bus.press !== 5'b0) begin n_fail++; $display("FAIL pulse_press_clr got=%b exp=00000", bus.press); end
    bus.btn_in = 5'b10000;
    tick();
    n_checks++; if (bus.press !== 5'b10000) begin n_fail++; $display("FAIL pulse_repress got=%b exp=10000", bus.press); end
    idle(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_long_hold(0);
    test_long_hold(3);
    test_short_press();
    test_simultaneous();
    test_release_at_long();
    test_reset_mid_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
